// File: rtl/xnor_array_bist_if.sv
// Handshake/bus bundle between the XNOR-array BIST sequencer and its controller/array.
interface xnor_array_bist_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] gate_in;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [15:0]      err_count;
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;
    logic [WIDTH-1:0] fail_got;

    modport master (
        output start, stop, gate_in,
        input  a_out, b_out, busy, done, pass, err_count, fail_a, fail_b, fail_got
    );

    modport slave (
        input  start, stop, gate_in,
        output a_out, b_out, busy, done, pass, err_count, fail_a, fail_b, fail_got
    );
endinterface

// File: rtl/xnor_array_bist.sv
// BIST sweep for a WIDTH-bit XNOR array: drives a/b, checks gate_in against ~(a^b).
// Each vector lasts SETTLE+1 cycles; no backpressure, stop aborts a sweep immediately.
module xnor_array_bist #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    xnor_array_bist_if.slave  bus
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WIDTH-1:0] ONES   = '1;
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] LAST_A = ONES >> 1;
    localparam logic [CW-1:0]    CNT_INIT = CW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, HOLD, CHECK, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] fail_a_q, fail_b_q, fail_got_q;
    logic [15:0]      err_q;
    logic             busy_q, done_q, pass_q;

    logic             mismatch;
    logic             last_vec;
    logic [15:0]      err_inc;

    assign mismatch = (bus.gate_in != ~(a_q ^ b_q));
    assign last_vec = (a_q == LAST_A) && (b_q == ONE);
    assign err_inc  = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            err_q      <= '0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_got_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // start wins over a simultaneous stop here: stop only matters mid-sweep
                    if (bus.start) begin
                        a_q        <= ONE;
                        b_q        <= ONES;
                        err_q      <= '0;
                        fail_a_q   <= '0;
                        fail_b_q   <= '0;
                        fail_got_q <= '0;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        cnt        <= CNT_INIT;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.stop) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CHECK: begin
                    if (bus.stop) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        if (mismatch) begin
                            err_q <= err_inc;
                            if (err_q == '0) begin
                                fail_a_q   <= a_q;
                                fail_b_q   <= b_q;
                                fail_got_q <= bus.gate_in;
                            end
                        end
                        // pass must include a mismatch on the final vector itself
                        if (last_vec) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= !mismatch && (err_q == '0);
                            state  <= DONE;
                        end else begin
                            if (b_q == ONE) begin
                                b_q <= ONES;
                                a_q <= (a_q << 1) | ONE;
                            end else begin
                                b_q <= b_q >> 1;
                            end
                            cnt   <= CNT_INIT;
                            state <= HOLD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_a    = fail_a_q;
    assign bus.fail_b    = fail_b_q;
    assign bus.fail_got  = fail_got_q;
endmodule

// File: tb/tb_xnor_array_bist.sv
// Bench for xnor_array_bist: two instances (SETTLE=1 and SETTLE=3) against a timeline-based model.
module tb_xnor_array_bist;
    localparam int W = 16;
    localparam int N = (W - 1) * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start_v [2];
    logic          stop_v  [2];
    int            mode_v  [2];
    logic [W-1:0]  rnd_sel;
    logic [W-1:0]  rnd_flip;

    int errors = 0;
    int checks = 0;

    xnor_array_bist_if #(.WIDTH(W)) if1 ();
    xnor_array_bist_if #(.WIDTH(W)) if3 ();

    // Array under test: ideal XNOR with optional injected faults.
    function automatic logic [W-1:0] gate_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input int mode, input logic [W-1:0] sel,
                                             input logic [W-1:0] flip);
        logic [W-1:0] g;
        g = ~(a ^ b);
        case (mode)
            1: g[0] = 1'b0;
            2: if (a == 16'h00FF && b == 16'h00FF) g = ~g;
            3: if (((a ^ {b[7:0], b[15:8]}) & 16'h000F) == sel) g = g ^ flip;
            default: ;
        endcase
        return g;
    endfunction

    assign if1.start   = start_v[0];
    assign if1.stop    = stop_v[0];
    assign if1.gate_in = gate_fn(if1.a_out, if1.b_out, mode_v[0], rnd_sel, rnd_flip);
    assign if3.start   = start_v[1];
    assign if3.stop    = stop_v[1];
    assign if3.gate_in = gate_fn(if3.a_out, if3.b_out, mode_v[1], rnd_sel, rnd_flip);

    xnor_array_bist #(.WIDTH(W), .SETTLE(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
    xnor_array_bist #(.WIDTH(W), .SETTLE(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3));

    logic [W-1:0] o_a [2], o_b [2], o_fa [2], o_fb [2], o_fg [2];
    logic [15:0]  o_err [2];
    logic         o_busy [2], o_done [2], o_pass [2];
    assign o_a[0] = if1.a_out;      assign o_a[1] = if3.a_out;
    assign o_b[0] = if1.b_out;      assign o_b[1] = if3.b_out;
    assign o_fa[0] = if1.fail_a;    assign o_fa[1] = if3.fail_a;
    assign o_fb[0] = if1.fail_b;    assign o_fb[1] = if3.fail_b;
    assign o_fg[0] = if1.fail_got;  assign o_fg[1] = if3.fail_got;
    assign o_err[0] = if1.err_count; assign o_err[1] = if3.err_count;
    assign o_busy[0] = if1.busy;    assign o_busy[1] = if3.busy;
    assign o_done[0] = if1.done;    assign o_done[1] = if3.done;
    assign o_pass[0] = if1.pass;    assign o_pass[1] = if3.pass;

    task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%h expected=%h at %0t", name, d, got, exp, $time);
        end
    endtask

    // Reference: the sweep is a fixed vector list; cycle t of a sweep shows vector t/(S+1).
    logic [W-1:0] vec_a [N], vec_b [N];
    int           settle_c [2] = '{1, 3};
    bit           act [2], ab_known [2];
    int           t [2];
    logic [W-1:0] ea [2], eb [2], e_fa [2], e_fb [2], e_fg [2];
    logic [15:0]  e_err [2];
    logic         e_busy [2], e_done [2], e_pass [2];
    int           busy_cnt [2];

    initial begin
        int k;
        logic [W-1:0] a, b;
        k = 0;
        a = 1;
        for (int i = 0; i < W - 1; i++) begin
            b = '1;
            for (int j = 0; j < W; j++) begin
                vec_a[k] = a;
                vec_b[k] = b;
                k++;
                b = b >> 1;
            end
            a = (a << 1) | 1;
        end
    end

    initial forever begin
        int s1, k;
        logic [W-1:0] g;
        @(posedge clk or posedge reset);
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                act[d] = 0; ab_known[d] = 1; t[d] = 0;
                ea[d] = '0; eb[d] = '0; e_fa[d] = '0; e_fb[d] = '0; e_fg[d] = '0;
                e_err[d] = '0; e_busy[d] = 0; e_done[d] = 0; e_pass[d] = 0;
            end else if (act[d]) begin
                if (stop_v[d]) begin
                    act[d] = 0; e_busy[d] = 0; e_done[d] = 0; ab_known[d] = 0;
                end else begin
                    s1 = settle_c[d] + 1;
                    k  = t[d] / s1;
                    if (t[d] % s1 == settle_c[d]) begin
                        g = gate_fn(vec_a[k], vec_b[k], mode_v[d], rnd_sel, rnd_flip);
                        if (g != ~(vec_a[k] ^ vec_b[k])) begin
                            if (e_err[d] == 0) begin
                                e_fa[d] = vec_a[k]; e_fb[d] = vec_b[k]; e_fg[d] = g;
                            end
                            if (e_err[d] != 16'hFFFF) e_err[d] = e_err[d] + 1;
                        end
                        if (k == N - 1) begin
                            act[d] = 0; e_busy[d] = 0; e_done[d] = 1; e_pass[d] = (e_err[d] == 0);
                        end
                    end
                    if (act[d]) begin
                        t[d]++;
                        ea[d] = vec_a[t[d] / s1];
                        eb[d] = vec_b[t[d] / s1];
                    end
                end
            end else if (start_v[d]) begin
                act[d] = 1; t[d] = 0; ab_known[d] = 1;
                ea[d] = vec_a[0]; eb[d] = vec_b[0];
                e_busy[d] = 1; e_done[d] = 0; e_pass[d] = 0; e_err[d] = '0;
                e_fa[d] = '0; e_fb[d] = '0; e_fg[d] = '0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (ab_known[d]) begin
                chk("a_out", d, 32'(o_a[d]), 32'(ea[d]));
                chk("b_out", d, 32'(o_b[d]), 32'(eb[d]));
            end
            chk("busy", d, 32'(o_busy[d]), 32'(e_busy[d]));
            chk("done", d, 32'(o_done[d]), 32'(e_done[d]));
            chk("pass", d, 32'(o_pass[d]), 32'(e_pass[d]));
            chk("err_count", d, 32'(o_err[d]), 32'(e_err[d]));
            chk("fail_a", d, 32'(o_fa[d]), 32'(e_fa[d]));
            chk("fail_b", d, 32'(o_fb[d]), 32'(e_fb[d]));
            chk("fail_got", d, 32'(o_fg[d]), 32'(e_fg[d]));
            if (o_busy[d]) busy_cnt[d]++;
        end
    end

    task automatic pulse_start(input int d);
        @(negedge clk);
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget);
        int n;
        n = 0;
        while (!o_done[d] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", d, 32'(o_done[d]), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        start_v[0] = 0; start_v[1] = 0; stop_v[0] = 0; stop_v[1] = 0;
        mode_v[0] = 0; mode_v[1] = 0;
        rnd_sel = '0; rnd_flip = 16'h0001;
        busy_cnt[0] = 0; busy_cnt[1] = 0;
        @(negedge clk);
        chk("rst_a_out", 0, 32'(o_a[0]), 32'h0);
        chk("rst_busy", 0, 32'(o_busy[0]), 32'h0);
        chk("rst_err", 1, 32'(o_err[1]), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Ideal array, default timing, start pulses while busy must be ignored.
        busy_cnt[0] = 0;
        pulse_start(0);
        chk("first_a", 0, 32'(o_a[0]), 32'h0001);
        chk("first_b", 0, 32'(o_b[0]), 32'hFFFF);
        repeat (60) begin
            @(negedge clk);
            start_v[0] = ($urandom_range(0, 3) == 0);
        end
        start_v[0] = 1'b0;
        wait_done(0, 2000);
        chk("busy_cycles", 0, 32'(busy_cnt[0]), 32'd480);
        chk("ideal_pass", 0, 32'(o_pass[0]), 32'd1);
        chk("ideal_err", 0, 32'(o_err[0]), 32'd0);
        chk("last_a", 0, 32'(o_a[0]), 32'h7FFF);
        chk("last_b", 0, 32'(o_b[0]), 32'h0001);

        // Bit 0 stuck at zero fails every vector.
        mode_v[0] = 1;
        pulse_start(0);
        wait_done(0, 2000);
        chk("stuck_err", 0, 32'(o_err[0]), 32'd240);
        chk("stuck_pass", 0, 32'(o_pass[0]), 32'd0);
        chk("stuck_fa", 0, 32'(o_fa[0]), 32'h0001);
        chk("stuck_fb", 0, 32'(o_fb[0]), 32'hFFFF);
        chk("stuck_fg", 0, 32'(o_fg[0]), 32'h0000);

        // Single faulty vector.
        mode_v[0] = 2;
        pulse_start(0);
        wait_done(0, 2000);
        chk("single_err", 0, 32'(o_err[0]), 32'd1);
        chk("single_pass", 0, 32'(o_pass[0]), 32'd0);
        chk("single_fa", 0, 32'(o_fa[0]), 32'h00FF);
        chk("single_fb", 0, 32'(o_fb[0]), 32'h00FF);
        chk("single_fg", 0, 32'(o_fg[0]), 32'h0000);

        // SETTLE=3 instance.
        busy_cnt[1] = 0;
        pulse_start(1);
        wait_done(1, 4000);
        chk("s3_busy_cycles", 1, 32'(busy_cnt[1]), 32'd960);
        chk("s3_pass", 1, 32'(o_pass[1]), 32'd1);

        // Asynchronous reset mid-cycle during vector 100, then a clean sweep.
        mode_v[0] = 1;
        pulse_start(0);
        repeat (200) @(negedge clk);
        chk("v100_a", 0, 32'(o_a[0]), 32'(vec_a[100]));
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_a", 0, 32'(o_a[0]), 32'h0);
        chk("arst_b", 0, 32'(o_b[0]), 32'h0);
        chk("arst_busy", 0, 32'(o_busy[0]), 32'h0);
        chk("arst_err", 0, 32'(o_err[0]), 32'h0);
        chk("arst_fa", 0, 32'(o_fa[0]), 32'h0);
        chk("arst_done", 1, 32'(o_done[1]), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mode_v[0] = 0;
        pulse_start(0);
        wait_done(0, 2000);
        chk("post_rst_pass", 0, 32'(o_pass[0]), 32'd1);

        // Random faults: stop near vector 50, start+stop together from IDLE, restart from DONE.
        for (int r = 0; r < 3; r++) begin
            mode_v[0] = 3;
            rnd_sel  = W'($urandom_range(0, 15));
            rnd_flip = W'($urandom) | 16'h0001;
            pulse_start(0);
            repeat (100 + $urandom_range(0, 1)) @(negedge clk);
            stop_v[0] = 1'b1;
            @(negedge clk);
            stop_v[0] = 1'b0;
            chk("stop_busy", 0, 32'(o_busy[0]), 32'd0);
            chk("stop_done", 0, 32'(o_done[0]), 32'd0);
            repeat (3) @(negedge clk);
            start_v[0] = 1'b1;
            stop_v[0]  = 1'b1;
            @(negedge clk);
            start_v[0] = 1'b0;
            stop_v[0]  = 1'b0;
            chk("start_wins", 0, 32'(o_busy[0]), 32'd1);
            wait_done(0, 2000);
            mode_v[0] = 0;
            pulse_start(0);
            chk("restart_err", 0, 32'(o_err[0]), 32'd0);
            chk("restart_fa", 0, 32'(o_fa[0]), 32'd0);
            chk("restart_fg", 0, 32'(o_fg[0]), 32'd0);
            chk("restart_done", 0, 32'(o_done[0]), 32'd0);
            wait_done(0, 2000);
            chk("restart_pass", 0, 32'(o_pass[0]), 32'd1);
        end

        // Random fault pattern on the slow instance as well.
        mode_v[1] = 3;
        rnd_sel  = W'($urandom_range(0, 15));
        rnd_flip = W'($urandom) | 16'h8000;
        pulse_start(1);
        wait_done(1, 4000);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/xnor_array_bist.md
Name: xnor_array_bist

Overview:
- Built-in self-test sequencer for a WIDTH-bit vector XNOR gate array (one 2-input XNOR per bit).
- Drives operand vectors a/b into the array, waits a programmable settle time, and compares the array output against ~(a ^ b).
- Reports pass/fail, an error count and the first failing vector.
- Sits beside the gate array under test. The array itself is external; its output returns on gate_in.

Parameters:
- WIDTH, 16, operand/result width in bits (min 2).
- SETTLE, 1, number of cycles a vector is held before the CHECK cycle (min 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- stop  input  1  abort the sweep; return to IDLE.
- gate_in  input  WIDTH  output of the XNOR array under test.
- a_out  output  WIDTH  operand A to the array (registered).
- b_out  output  WIDTH  operand B to the array (registered).
- busy  output  1  sweep in progress.
- done  output  1  sweep completed; held until the next start or reset.
- pass  output  1  valid when done=1; 1 means no mismatches.
- err_count  output  16  number of mismatching vectors; saturates at 16'hFFFF.
- fail_a  output  WIDTH  a_out of the first mismatch.
- fail_b  output  WIDTH  b_out of the first mismatch.
- fail_got  output  WIDTH  gate_in captured at the first mismatch.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs go to 0: a_out, b_out, busy, done, pass, err_count, fail_a, fail_b, fail_got.
- Sweep order, nested:
  - Outer loop: a = 1, then a = (a<<1)|1, up to and including 2^(WIDTH-1)-1. The all-ones value is excluded, giving WIDTH-1 values.
  - Inner loop: b = all-ones, then b = b>>1, down to and including 1, giving WIDTH values.
  - Total vectors: (WIDTH-1)*WIDTH. For WIDTH=16 this is 240.
- States: IDLE, HOLD, CHECK, DONE.
- IDLE:
  - On start=1 at a clock edge: load a_out=1 and b_out=all-ones.
  - Clear err_count, fail_*, done and pass; set busy=1; go to HOLD with settle counter = SETTLE-1.
- HOLD:
  - Counter decrements each cycle. At 0, go to CHECK.
  - Time in HOLD is SETTLE cycles.
- CHECK (one cycle):
  - Compare gate_in with ~(a_out ^ b_out).
  - On mismatch: increment err_count (saturating). If this is the first mismatch (err_count was 0), capture fail_a, fail_b and fail_got.
  - Same edge, advance the vector: if b_out==1, set b_out=all-ones and a_out=(a_out<<1)|1; otherwise b_out=b_out>>1. Go to HOLD.
  - If the current vector is the last one (a_out==2^(WIDTH-1)-1 and b_out==1): go to DONE instead, with busy=0, done=1, pass=(final err_count==0). a_out/b_out hold their last values.
- Timing:
  - Each vector is stable on a_out/b_out for exactly SETTLE+1 cycles.
  - busy is high for (WIDTH-1)*WIDTH*(SETTLE+1) cycles: 480 at the defaults.
- DONE:
  - Outputs hold.
  - start=1 restarts exactly as from IDLE.
- stop:
  - In HOLD or CHECK, stop=1 takes priority over everything, including the compare.
  - Next state is IDLE with busy=0 and done=0; err_count and fail_* hold.
  - Ignored in IDLE and DONE.
- start while busy: ignored.
- start and stop in the same cycle while in IDLE or DONE: start wins.
- A mismatch in the CHECK cycle of the last vector is counted before pass is computed.

Test Plan:
- Ideal array model (gate_in = ~(a_out^b_out) combinationally), defaults, start pulse -> busy high exactly 480 cycles; then done=1, pass=1, err_count=0; first vector a_out=16'h0001, b_out=16'hFFFF; last vector a_out=16'h7FFF, b_out=16'h0001.
- Bit 0 of gate_in stuck at 0 -> done=1, pass=0, err_count=240, fail_a=16'h0001, fail_b=16'hFFFF, fail_got=16'h0000.
- Single fault: invert gate_in only when a_out=16'h00FF and b_out=16'h00FF -> err_count=1, fail_a=16'h00FF, fail_b=16'h00FF, fail_got=16'h0000, pass=0.
- SETTLE=3 with the ideal model -> every a_out/b_out value is held 4 cycles; busy for 960 cycles; pass=1.
- Assert reset asynchronously (mid-cycle) during vector 100 -> all outputs 0 immediately, state IDLE; a following start runs a full clean sweep with pass=1.
- start pulses while busy have no effect; stop at vector 50 -> busy=0, done=0 next cycle, err_count held; start from DONE clears err_count and fail_*.
